pwm_sample_fetcher: RTL and testbench
=====================================

Name: pwm_sample_fetcher

Overview:
Upstream feeder for the PWM audio DMA bridge. It walks a sample buffer in memory, issuing single-word read requests on the bridge's dma_* request port, and buffers returned words in a small FIFO. It unpacks each 32-bit word into two 16-bit PCM samples and streams them to the PWM generator over a valid/ready handshake. It supports one-shot and looped playback, stop, done and underrun reporting.

Parameters:
FIFO_DEPTH, 4, word FIFO depth; power of two, >=2
ADDR_STEP, 4, byte increment between consecutive words

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begin playback (ignored while busy)
stop  in  1  one-cycle pulse; abort playback
cfg_base  in  32  byte address of first word, sampled on start
cfg_words  in  16  number of 32-bit words, sampled on start
cfg_loop  in  1  1 = restart at cfg_base after last word, sampled on start
busy  out  1  high from start accept until idle
done  out  1  one-cycle pulse when a one-shot buffer is fully consumed
underrun  out  1  one-cycle pulse per cycle the sink waits on an empty stream mid-playback
dma_addr  out  32  request address to DMA bridge
dma_read  out  1  read request pulse
dma_write  out  1  tied 0
dma_writedata  out  32  tied 0
dma_readdata  in  32  returned word, valid when dma_rdy
dma_rdy  in  1  one-cycle completion from bridge
smp_data  out  16  PCM sample
smp_valid  out  1  smp_data valid
smp_ready  in  1  sink accepts sample

Behaviour:
- Reset (rst low, async): all outputs 0, FIFO empty, half-select = low, state IDLE.
- States: IDLE, REQ, WAIT, DRAIN, ABORT.
- IDLE: on start with cfg_words != 0, latch base/count/loop, set addr = cfg_base, enter REQ, busy = 1. On start with cfg_words == 0, pulse done in the next cycle, issue no reads, busy stays 0.
- REQ: when FIFO fill < FIFO_DEPTH, assert dma_read for exactly one cycle with dma_addr = addr, then enter WAIT. Otherwise hold with dma_read = 0. dma_read is registered: the first request appears in the cycle after start is sampled.
- WAIT: dma_addr stays stable until dma_rdy. On dma_rdy, push dma_readdata, addr += ADDR_STEP (mod 2^32), remaining -= 1. If remaining reaches 0: with loop, reload addr/remaining and go to REQ; otherwise go to DRAIN. If remaining is nonzero, go to REQ.
- Only one outstanding read at a time. Reads are never issued without a free FIFO slot.
- DRAIN: when the FIFO is empty and the last high half has been accepted, pulse done, clear busy, go to IDLE.
- stop: in REQ or DRAIN, flush the FIFO and go to IDLE next cycle. In WAIT, go to ABORT. In ABORT, wait for dma_rdy, discard the word, then go to IDLE. The bridge transaction cannot be cancelled. stop never produces a done pulse. busy drops on entry to IDLE.
- Simultaneous start and stop while IDLE: stop wins, start is ignored.
- Unpacker:
  - smp_valid = FIFO non-empty and state != ABORT.
  - smp_data = FIFO head [15:0] when half = 0, [31:16] when half = 1.
  - On smp_valid & smp_ready, toggle half; pop the head when the high half is accepted.
  - Push and pop in the same cycle are allowed; fill stays the same.
- underrun: in REQ/WAIT, pulses for each cycle with smp_ready = 1 and smp_valid = 0. Never asserted in IDLE, DRAIN or ABORT.
- First sample: smp_valid rises in the cycle after dma_rdy is sampled.

Test Plan:
- One-shot: base 0x1000, words 2; mem[0x1000] = 0x1111_2222, mem[0x1004] = 0x3333_4444; smp_ready = 1 -> reads at 0x1000 then 0x1004; samples 0x2222, 0x1111, 0x4444, 0x3333; one done pulse; busy low afterwards.
- Backpressure: words 8, smp_ready = 0 -> exactly 4 dma_read pulses, then dma_read stays low. Raising smp_ready -> 4 more reads; 16 samples in address order, none dropped or duplicated.
- Loop: words 2, loop = 1 -> address sequence 0x1000, 0x1004, 0x1000, 0x1004, ...; never done. stop -> FIFO flushed, smp_valid = 0 next cycle, busy = 0.
- Stop in WAIT with bridge dma_rdy delayed 5 cycles -> no further dma_read; returned word discarded; smp_valid = 0; busy falls the cycle after dma_rdy; no done.
- Zero length: words 0 -> no dma_read, done pulse the cycle after start, busy stays 0. start while busy is ignored.
- Async reset: rst low mid-WAIT -> busy, dma_read, smp_valid and done go 0 immediately without a clock edge. After release, a new start fetches from the new cfg_base.

Source files
------------

// File: rtl/pwm_sample_fetcher_if.sv
// DMA read-request bus toward the bridge plus the 16-bit PCM sample stream toward the PWM generator.
// The master side is the fetcher; the slave side is the bridge/sink pair.
interface pwm_sample_fetcher_if;
   logic [31:0] dma_addr;
   logic        dma_read;
   logic        dma_write;
   logic [31:0] dma_writedata;
   logic [31:0] dma_readdata;
   logic        dma_rdy;
   logic [15:0] smp_data;
   logic        smp_valid;
   logic        smp_ready;

   modport master (
      output dma_addr, dma_read, dma_write, dma_writedata, smp_data, smp_valid,
      input  dma_readdata, dma_rdy, smp_ready
   );

   modport slave (
      input  dma_addr, dma_read, dma_write, dma_writedata, smp_data, smp_valid,
      output dma_readdata, dma_rdy, smp_ready
   );
endinterface

// File: rtl/pwm_sample_fetcher.sv
// Walks a sample buffer with single-word DMA reads, queues the words in a small FIFO
// and streams each word out as two 16-bit PCM samples, low half first.
module pwm_sample_fetcher #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ADDR_STEP  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [31:0]          cfg_base_i,
   input  logic [15:0]          cfg_words_i,
   input  logic                 cfg_loop_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 underrun_o,
   pwm_sample_fetcher_if.master bus
);
   localparam int unsigned      PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0]   FILL_MAX = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   FILL_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN, ST_ABORT} state_e;

   state_e           state_q;
   logic [31:0]      addr_q;
   logic [31:0]      base_q;
   logic [15:0]      remaining_q;
   logic [15:0]      words_q;
   logic             loop_q;
   logic             busy_q;
   logic             done_q;
   logic             dmaRead_q;
   logic             halfSel_q;
   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W:0]   fillCount_q;
   logic [PTR_W:0]   fillCount_d;

   logic [31:0]      headWord;
   logic             smpValid;
   logic             smpAccept;
   logic             push;
   logic             pop;
   logic             flush;

   assign headWord  = mem_q[rdPtr_q];
   assign smpValid  = (fillCount_q != '0) && (state_q != ST_ABORT);
   assign smpAccept = smpValid && bus.smp_ready;
   assign pop       = smpAccept && halfSel_q;
   assign push      = (state_q == ST_WAIT) && bus.dma_rdy;
   assign flush     = stop_i && ((state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN));

   always_comb begin
      fillCount_d = fillCount_q;
      if (push && !pop) begin
         fillCount_d = fillCount_q + FILL_ONE;
      end else if (pop && !push) begin
         fillCount_d = fillCount_q - FILL_ONE;
      end
   end

   // Word FIFO plus half-select; a stop discards everything queued, including a word landing this cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fillCount_q <= '0;
         halfSel_q   <= 1'b0;
      end else if (flush) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fillCount_q <= '0;
         halfSel_q   <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wrPtr_q] <= bus.dma_readdata;
            wrPtr_q        <= wrPtr_q + PTR_ONE;
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PTR_ONE;
         end
         if (smpAccept) begin
            halfSel_q <= ~halfSel_q;
         end
         fillCount_q <= fillCount_d;
      end
   end

   // Fetch sequencer; a read is only requested with a free FIFO slot and never overlaps another.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         base_q      <= '0;
         remaining_q <= '0;
         words_q     <= '0;
         loop_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dmaRead_q   <= 1'b0;
      end else begin
         dmaRead_q <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i && !stop_i) begin
                  if (cfg_words_i != 16'd0) begin
                     base_q      <= cfg_base_i;
                     words_q     <= cfg_words_i;
                     loop_q      <= cfg_loop_i;
                     addr_q      <= cfg_base_i;
                     remaining_q <= cfg_words_i;
                     busy_q      <= 1'b1;
                     state_q     <= ST_REQ;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (stop_i) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (fillCount_q < FILL_MAX) begin
                  dmaRead_q <= 1'b1;
                  state_q   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // The bridge cannot cancel a transaction, so a stop must still absorb its completion.
               if (stop_i) begin
                  if (bus.dma_rdy) begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     state_q <= ST_ABORT;
                  end
               end else if (bus.dma_rdy) begin
                  if (remaining_q == 16'd1) begin
                     if (loop_q) begin
                        addr_q      <= base_q;
                        remaining_q <= words_q;
                        state_q     <= ST_REQ;
                     end else begin
                        addr_q      <= addr_q + 32'(ADDR_STEP);
                        remaining_q <= 16'd0;
                        state_q     <= ST_DRAIN;
                     end
                  end else begin
                     addr_q      <= addr_q + 32'(ADDR_STEP);
                     remaining_q <= remaining_q - 16'd1;
                     state_q     <= ST_REQ;
                  end
               end
            end
            ST_DRAIN: begin
               if (stop_i || (fillCount_q == '0)) begin
                  done_q  <= !stop_i;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_ABORT: begin
               if (bus.dma_rdy) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.dma_addr      = addr_q;
   assign bus.dma_read      = dmaRead_q;
   assign bus.dma_write     = 1'b0;
   assign bus.dma_writedata = 32'd0;
   assign bus.smp_data      = halfSel_q ? headWord[31:16] : headWord[15:0];
   assign bus.smp_valid     = smpValid;

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign underrun_o = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && bus.smp_ready && !smpValid;
endmodule

// File: tb/tb_pwm_sample_fetcher.sv
// Bench for pwm_sample_fetcher: a memory/bridge model with configurable latency, a sink monitor,
// and a reference model that lists the expected read addresses and PCM samples for each run.
module tb_pwm_sample_fetcher;
   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic [31:0] cfgBase;
   logic [15:0] cfgWords;
   logic        cfgLoop;
   logic        busy;
   logic        done;
   logic        underrun;

   int compared   = 0;
   int mismatched = 0;

   int bridgeLat;
   int bridgeWait;
   logic [31:0] reqAddr;

   logic [31:0] readQ[$];
   logic [15:0] smpQ[$];
   logic [31:0] expAddrQ[$];
   logic [15:0] expSmpQ[$];
   int doneCnt;
   int underrunCnt;

   pwm_sample_fetcher_if bus ();

   pwm_sample_fetcher #(
      .FIFO_DEPTH(4),
      .ADDR_STEP (4)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .stop_i     (stop),
      .cfg_base_i (cfgBase),
      .cfg_words_i(cfgWords),
      .cfg_loop_i (cfgLoop),
      .busy_o     (busy),
      .done_o     (done),
      .underrun_o (underrun),
      .bus        (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h1111_2222;
      if (a == 32'h0000_1004) return 32'h3333_4444;
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
   endfunction

   // Bridge: answers each read after bridgeLat cycles (random 0..3 when negative).
   initial begin
      bus.dma_rdy      = 1'b0;
      bus.dma_readdata = 32'd0;
      forever begin
         @(negedge clk);
         if (bus.dma_read === 1'b1) begin
            reqAddr    = bus.dma_addr;
            bridgeWait = (bridgeLat < 0) ? int'($urandom_range(0, 3)) : bridgeLat;
            repeat (bridgeWait) @(negedge clk);
            bus.dma_readdata = memWord(reqAddr);
            bus.dma_rdy      = 1'b1;
            @(negedge clk);
            bus.dma_rdy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.dma_read === 1'b1) readQ.push_back(bus.dma_addr);
         if (bus.smp_valid === 1'b1 && bus.smp_ready === 1'b1) smpQ.push_back(bus.smp_data);
         if (done === 1'b1) doneCnt++;
         if (underrun === 1'b1) underrunCnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] base, input logic [15:0] words, input logic loopMode);
      cfgBase  = base;
      cfgWords = words;
      cfgLoop  = loopMode;
      start    = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clearRun();
      readQ.delete();
      smpQ.delete();
      doneCnt     = 0;
      underrunCnt = 0;
   endtask

   task automatic buildExpected(input logic [31:0] base, input int words);
      logic [31:0] a;
      logic [31:0] w;
      expAddrQ.delete();
      expSmpQ.delete();
      for (int i = 0; i < words; i++) begin
         a = base + 32'(i) * 32'd4;
         w = memWord(a);
         expAddrQ.push_back(a);
         expSmpQ.push_back(w[15:0]);
         expSmpQ.push_back(w[31:16]);
      end
   endtask

   task automatic runUntilIdle(input int budget, input bit randReady);
      int n = 0;
      while (busy === 1'b1 && n < budget) begin
         if (randReady) bus.smp_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end
      checkOutput("idleTimeout", 32'(busy), 32'd0);
   endtask

   task automatic compareRun(input string name);
      checkOutput({name, "_nReads"}, 32'(readQ.size()), 32'(expAddrQ.size()));
      for (int i = 0; i < expAddrQ.size(); i++)
         checkOutput($sformatf("%s_addr%0d", name, i), (i < readQ.size()) ? readQ[i] : 32'hxxxx_xxxx, expAddrQ[i]);
      checkOutput({name, "_nSamples"}, 32'(smpQ.size()), 32'(expSmpQ.size()));
      for (int i = 0; i < expSmpQ.size(); i++)
         checkOutput($sformatf("%s_smp%0d", name, i), (i < smpQ.size()) ? 32'(smpQ[i]) : 32'hxxxx_xxxx, 32'(expSmpQ[i]));
   endtask

   initial begin
      int n;
      bit busyHeld;
      logic [31:0] b;
      logic [15:0] w;
      logic [31:0] firstWord;

      rst_n = 1'b0; start = 1'b0; stop = 1'b0;
      cfgBase = '0; cfgWords = '0; cfgLoop = 1'b0;
      bus.smp_ready = 1'b0;
      bridgeLat = 0;
      clearRun();
      repeat (3) tick();
      checkOutput("rst_busyDuring", 32'(busy), 32'd0);
      checkOutput("rst_validDuring", 32'(bus.smp_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_underrun", 32'(underrun), 32'd0);
      checkOutput("rst_dmaRead", 32'(bus.dma_read), 32'd0);
      checkOutput("rst_dmaAddr", bus.dma_addr, 32'd0);
      checkOutput("rst_dmaWrite", 32'(bus.dma_write), 32'd0);
      checkOutput("rst_smpValid", 32'(bus.smp_valid), 32'd0);

      // One-shot, two words, sink always ready.
      $display("[TB] one-shot");
      clearRun();
      bus.smp_ready = 1'b1;
      applyStimulus(32'h0000_1000, 16'd2, 1'b0);
      checkOutput("os_busyRise", 32'(busy), 32'd1);
      runUntilIdle(100, 1'b0);
      checkOutput("os_donePulse", 32'(done), 32'd1);
      tick();
      checkOutput("os_doneDrop", 32'(done), 32'd0);
      buildExpected(32'h0000_1000, 2);
      compareRun("os");
      checkOutput("os_doneCount", 32'(doneCnt), 32'd1);
      checkOutput("os_underrunSeen", 32'(underrunCnt > 0), 32'd1);

      // Backpressure: FIFO fills after FIFO_DEPTH reads, then drains in order.
      $display("[TB] backpressure");
      clearRun();
      bridgeLat = -1;
      bus.smp_ready = 1'b0;
      applyStimulus(32'h0000_2000, 16'd8, 1'b0);
      repeat (40) tick();
      firstWord = memWord(32'h0000_2000);
      checkOutput("bp_readsWhenFull", 32'(readQ.size()), 32'd4);
      checkOutput("bp_validWhenFull", 32'(bus.smp_valid), 32'd1);
      checkOutput("bp_headLow", 32'(bus.smp_data), 32'(firstWord[15:0]));
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_noUnderrun", 32'(underrunCnt), 32'd0);
      bus.smp_ready = 1'b1;
      runUntilIdle(300, 1'b0);
      tick();
      buildExpected(32'h0000_2000, 8);
      compareRun("bp");
      checkOutput("bp_doneCount", 32'(doneCnt), 32'd1);

      // Looped playback, then stop.
      $display("[TB] loop");
      clearRun();
      bridgeLat = 1;
      bus.smp_ready = 1'b1;
      applyStimulus(32'h0000_1000, 16'd2, 1'b1);
      repeat (40) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checkOutput("lp_validAfterStop", 32'(bus.smp_valid), 32'd0);
      n = 0;
      while (busy === 1'b1 && n < 20) begin tick(); n++; end
      checkOutput("lp_busyAfterStop", 32'(busy), 32'd0);
      repeat (3) tick();
      checkOutput("lp_manyReads", 32'(readQ.size() >= 6), 32'd1);
      for (int i = 0; i < readQ.size(); i++)
         checkOutput($sformatf("lp_addr%0d", i), readQ[i], 32'h0000_1000 + 32'(i % 2) * 32'd4);
      buildExpected(32'h0000_1000, 2);
      for (int i = 0; i < smpQ.size(); i++)
         checkOutput($sformatf("lp_smp%0d", i), 32'(smpQ[i]), 32'(expSmpQ[i % 4]));
      checkOutput("lp_noDone", 32'(doneCnt), 32'd0);

      // Stop while a read is outstanding; the late completion must be swallowed.
      $display("[TB] stop in wait");
      clearRun();
      bridgeLat = 5;
      bus.smp_ready = 1'b0;
      applyStimulus(32'h0000_6000, 16'd4, 1'b0);
      n = 0;
      while (readQ.size() < 2 && n < 40) begin tick(); n++; end
      checkOutput("sw_secondRead", 32'(readQ.size()), 32'd2);
      checkOutput("sw_validBefore", 32'(bus.smp_valid), 32'd1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checkOutput("sw_validAfterStop", 32'(bus.smp_valid), 32'd0);
      checkOutput("sw_busyInAbort", 32'(busy), 32'd1);
      busyHeld = 1'b1;
      n = 0;
      while (bus.dma_rdy !== 1'b1 && n < 20) begin
         if (busy !== 1'b1) busyHeld = 1'b0;
         tick();
         n++;
      end
      checkOutput("sw_rdySeen", 32'(bus.dma_rdy), 32'd1);
      checkOutput("sw_busyHeld", 32'(busyHeld), 32'd1);
      checkOutput("sw_busyFall", 32'(busy), 32'd0);
      repeat (12) tick();
      checkOutput("sw_noMoreReads", 32'(readQ.size()), 32'd2);
      checkOutput("sw_validAfter", 32'(bus.smp_valid), 32'd0);
      checkOutput("sw_noDone", 32'(doneCnt), 32'd0);

      // Zero length, start+stop together, and start while busy.
      $display("[TB] zero length and ignored starts");
      clearRun();
      bridgeLat = 2;
      bus.smp_ready = 1'b1;
      applyStimulus(32'h0000_3000, 16'd0, 1'b0);
      checkOutput("zl_donePulse", 32'(done), 32'd1);
      checkOutput("zl_busy", 32'(busy), 32'd0);
      tick();
      checkOutput("zl_doneDrop", 32'(done), 32'd0);
      stop = 1'b1;
      applyStimulus(32'h0000_3000, 16'd4, 1'b0);
      stop = 1'b0;
      checkOutput("ss_busy", 32'(busy), 32'd0);
      repeat (5) tick();
      checkOutput("zl_noReads", 32'(readQ.size()), 32'd0);
      checkOutput("zl_doneCount", 32'(doneCnt), 32'd1);
      clearRun();
      applyStimulus(32'h0000_4000, 16'd3, 1'b0);
      repeat (3) tick();
      applyStimulus(32'h0000_5000, 16'd5, 1'b0);
      runUntilIdle(200, 1'b0);
      tick();
      buildExpected(32'h0000_4000, 3);
      compareRun("sb");
      checkOutput("sb_doneCount", 32'(doneCnt), 32'd1);

      // Randomized runs, including an address wrap through 2^32.
      $display("[TB] randomized");
      bridgeLat = -1;
      for (int r = 0; r < 4; r++) begin
         clearRun();
         b = (r == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
         w = (r == 0) ? 16'd3 : 16'($urandom_range(1, 9));
         applyStimulus(b, w, 1'b0);
         runUntilIdle(600, 1'b1);
         checkOutput($sformatf("rnd%0d_donePulse", r), 32'(done), 32'd1);
         tick();
         buildExpected(b, int'(w));
         compareRun($sformatf("rnd%0d", r));
         checkOutput($sformatf("rnd%0d_doneCount", r), 32'(doneCnt), 32'd1);
      end

      // Asynchronous reset in the middle of an outstanding read.
      $display("[TB] async reset");
      clearRun();
      bridgeLat = 5;
      bus.smp_ready = 1'b1;
      applyStimulus(32'h0000_7000, 16'd4, 1'b0);
      n = 0;
      while (readQ.size() < 1 && n < 20) begin tick(); n++; end
      checkOutput("ar_readIssued", 32'(readQ.size()), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_busy", 32'(busy), 32'd0);
      checkOutput("ar_dmaRead", 32'(bus.dma_read), 32'd0);
      checkOutput("ar_smpValid", 32'(bus.smp_valid), 32'd0);
      checkOutput("ar_done", 32'(done), 32'd0);
      checkOutput("ar_dmaAddr", bus.dma_addr, 32'd0);
      repeat (10) tick();
      rst_n = 1'b1;
      tick();
      clearRun();
      bridgeLat = -1;
      applyStimulus(32'h0000_8000, 16'd3, 1'b0);
      runUntilIdle(200, 1'b0);
      tick();
      buildExpected(32'h0000_8000, 3);
      compareRun("ar");
      checkOutput("ar_doneCount", 32'(doneCnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
